// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared widths and entry type for the fetch-to-decode instruction queue.
package inst_queue_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W_DEF = 10;
  typedef struct packed {
    logic [INSTR_W-1:0]    instr;
    logic [ADDR_W_DEF-1:0] addr;
  } iq_entry_t;
endpackage

// File: rtl/iq_fifo.sv
// iq_fifo: circular entry storage with push/pop and a flush that overrides both.
module iq_fifo
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = INSTR_W + ADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]   cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    rd_d = flush ? '0 : pop ? rd_q + 1'b1 : rd_q;
    wr_d = flush ? '0 : push ? wr_q + 1'b1 : wr_q;
    cnt_d = flush ? '0 : cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    if (push && !flush) mem_d[wr_q] = wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  assign count = cnt_q;
  assign full = cnt_q == (PW+1)'(DEPTH);
  assign rdata = (cnt_q != '0) ? mem_q[rd_q] : '0;
endmodule

// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode buffer owning the branch redirect, flush and wrong-path shadow discard.
// Optional IQ_SEQCHK_EN adds a sticky seq_err flag for non-sequential kept fetch addresses.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SHADOW = 1
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               f_valid,
  input  logic [INSTR_W-1:0] f_instr,
  input  logic [ADDR_W-1:0]  f_addr,
  output logic               f_stall,
  output logic               Branch,
  output logic [ADDR_W-1:0]  TargetAddress,
  input  logic               ex_taken,
  input  logic [ADDR_W-1:0]  ex_target,
  output logic               d_valid,
  input  logic               d_ready,
  output logic [INSTR_W-1:0] d_instr,
  output logic [ADDR_W-1:0]  d_addr,
  output logic               overflow
`ifdef IQ_SEQCHK_EN
  ,output logic              seq_err
`endif
);
  localparam int SW = $clog2(SHADOW + 2);
  logic [INSTR_W+ADDR_W-1:0] rdata;
  logic [$clog2(DEPTH):0]    count;
  logic                      full, pop, push, discard;
  logic                      branch_q, branch_d, overflow_q, overflow_d;
  logic [ADDR_W-1:0]         target_q, target_d;
  logic [SW-1:0]             shadow_q, shadow_d;
  iq_fifo #(.DEPTH(DEPTH), .W(INSTR_W + ADDR_W)) u_fifo (
    .clk(clk),
    .rst(Reset),
    .push(push),
    .pop(pop && !ex_taken),
    .flush(ex_taken),
    .wdata({f_instr, f_addr}),
    .rdata(rdata),
    .count(count),
    .full(full)
  );
  // A redirect this cycle flushes, so any same-cycle push is moot.
  always_comb begin
    d_valid = count != '0;
    pop = d_valid && d_ready;
    discard = branch_q || (shadow_q != '0);
    push = f_valid && !discard && !ex_taken && (!full || pop);
    f_stall = full && !pop;
    branch_d = ex_taken;
    target_d = ex_taken ? ex_target : target_q;
    shadow_d = branch_q ? SW'(SHADOW) : (shadow_q != '0) ? shadow_q - 1'b1 : '0;
    overflow_d = overflow_q || (f_valid && !discard && !ex_taken && full && !pop);
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      branch_q <= 1'b0;
      target_q <= '0;
      shadow_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      branch_q <= branch_d;
      target_q <= target_d;
      shadow_q <= shadow_d;
      overflow_q <= overflow_d;
    end
  end
  assign Branch = branch_q;
  assign TargetAddress = target_q;
  assign overflow = overflow_q;
  assign d_instr = rdata[ADDR_W +: INSTR_W];
  assign d_addr = rdata[ADDR_W-1:0];
`ifdef IQ_SEQCHK_EN
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic              seq_err_q, seq_err_d;
  always_comb begin
    exp_addr_d = ex_taken ? ex_target : push ? f_addr + 1'b1 : exp_addr_q;
    seq_err_d = seq_err_q || (push && f_addr != exp_addr_q);
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      exp_addr_q <= '0;
      seq_err_q <= 1'b0;
    end else begin
      exp_addr_q <= exp_addr_d;
      seq_err_q <= seq_err_d;
    end
  end
  assign seq_err = seq_err_q;
`endif
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed self-checking bench for inst_queue (DEPTH=4, ADDR_W=10, SHADOW=1).
module tb_inst_queue;
  logic        clk = 1'b0;
  logic        Reset, f_valid, ex_taken, d_ready;
  logic [31:0] f_instr;
  logic [9:0]  f_addr, ex_target;
  logic        f_stall, Branch, d_valid, overflow;
  logic [9:0]  TargetAddress, d_addr;
  logic [31:0] d_instr;
`ifdef IQ_SEQCHK_EN
  logic        seq_err;
`endif
  int checks = 0;
  int failures = 0;
  inst_queue #(.DEPTH(4), .ADDR_W(10), .SHADOW(1)) dut (
    .clk(clk),
    .Reset(Reset),
    .f_valid(f_valid),
    .f_instr(f_instr),
    .f_addr(f_addr),
    .f_stall(f_stall),
    .Branch(Branch),
    .TargetAddress(TargetAddress),
    .ex_taken(ex_taken),
    .ex_target(ex_target),
    .d_valid(d_valid),
    .d_ready(d_ready),
    .d_instr(d_instr),
    .d_addr(d_addr),
    .overflow(overflow)
`ifdef IQ_SEQCHK_EN
    ,.seq_err(seq_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [9:0] a);
    f_valid = 1'b1;
    f_addr = a;
    f_instr = 32'hC0DE_0000 | {22'b0, a};
    tick();
    f_valid = 1'b0;
  endtask
  initial begin
    Reset = 1'b1; f_valid = 1'b0; f_instr = '0; f_addr = '0;
    ex_taken = 1'b0; ex_target = '0; d_ready = 1'b0;
    tick(); tick();
    #1;
    chk("rst_d_valid", d_valid, 0);
    chk("rst_f_stall", f_stall, 0);
    chk("rst_branch", Branch, 0);
    chk("rst_target", TargetAddress, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_d_addr", d_addr, 0);
    chk("rst_d_instr", d_instr, 0);
    Reset = 1'b0;
    tick();
    // fill to DEPTH with decode stalled
    for (int i = 0; i < 4; i++) fetch(10'(i));
    #1;
    chk("full_cnt", 32'(dut.u_fifo.cnt_q), 4);
    chk("full_stall", f_stall, 1);
    chk("full_d_valid", d_valid, 1);
    chk("full_d_addr", d_addr, 0);
    chk("full_d_instr", d_instr, 32'hC0DE_0000);
    fetch(10'd4);
    #1;
    chk("ovf_set", overflow, 1);
    chk("ovf_cnt", 32'(dut.u_fifo.cnt_q), 4);
    d_ready = 1'b1;
    #1;
    chk("pop_stall_low", f_stall, 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_addr", d_addr, i);
      tick();
    end
    #1;
    chk("drain_empty", d_valid, 0);
    d_ready = 1'b0;
    for (int i = 0; i < 4; i++) fetch(10'(i));
    f_valid = 1'b1; f_addr = 10'd4; f_instr = 32'hC0DE_0004; d_ready = 1'b1;
    #1;
    chk("pp_stall", f_stall, 0);
    chk("pp_head", d_addr, 0);
    tick();
    f_valid = 1'b0;
    #1;
    chk("pp_cnt", 32'(dut.u_fifo.cnt_q), 4);
    chk("ovf_sticky", overflow, 1);
    for (int i = 1; i < 5; i++) begin
      chk("pp_order", d_addr, i);
      tick();
    end
    d_ready = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    chk("ovf_cleared", overflow, 0);
    fetch(10'h10);
    fetch(10'h11);
    ex_taken = 1'b1; ex_target = 10'h2A0; d_ready = 1'b1;
    f_valid = 1'b1; f_addr = 10'h12;
    tick();
    ex_taken = 1'b0; d_ready = 1'b0; f_addr = 10'h13;
    #1;
    chk("br_pulse", Branch, 1);
    chk("br_target", TargetAddress, 10'h2A0);
    chk("br_d_valid", d_valid, 0);
    chk("br_cnt", 32'(dut.u_fifo.cnt_q), 0);
    tick();
    f_addr = 10'h14;
    #1;
    chk("shadow_branch", Branch, 0);
    chk("shadow_d_valid", d_valid, 0);
    tick();
    fetch(10'h2A0);
    #1;
    chk("tgt_d_valid", d_valid, 1);
    chk("tgt_d_addr", d_addr, 10'h2A0);
    chk("tgt_d_instr", d_instr, 32'hC0DE_02A0);
    chk("tgt_cnt", 32'(dut.u_fifo.cnt_q), 1);
    chk("shadow_no_ovf", overflow, 0);
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    ex_taken = 1'b1; ex_target = 10'h100;
    tick();
    ex_target = 10'h200; f_valid = 1'b1; f_addr = 10'h100;
    #1;
    chk("b2b_first", TargetAddress, 10'h100);
    tick();
    ex_taken = 1'b0; f_addr = 10'h101;
    #1;
    chk("b2b_branch2", Branch, 1);
    chk("b2b_second", TargetAddress, 10'h200);
    tick();
    f_addr = 10'h102;
    #1;
    chk("b2b_shadow", Branch, 0);
    chk("b2b_no_valid", d_valid, 0);
    tick();
    fetch(10'h200);
    fetch(10'h201);
    #1;
    chk("b2b_head", d_addr, 10'h200);
    chk("b2b_cnt", 32'(dut.u_fifo.cnt_q), 2);
    d_ready = 1'b1;
    tick();
    chk("b2b_next", d_addr, 10'h201);
    tick();
    d_ready = 1'b0;
    ex_taken = 1'b1; ex_target = 10'h3FF;
    tick();
    ex_taken = 1'b0; Reset = 1'b1;
    #1;
    chk("mid_branch", Branch, 1);
    tick();
    Reset = 1'b0;
    #1;
    chk("mid_rst_branch", Branch, 0);
    chk("mid_rst_target", TargetAddress, 0);
    fetch(10'h55);
    #1;
    chk("post_rst_keep", d_addr, 10'h55);
    chk("post_rst_valid", d_valid, 1);
`ifdef IQ_SEQCHK_EN
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    ex_taken = 1'b1; ex_target = 10'h5;
    tick();
    ex_taken = 1'b0;
    tick(); tick();
    fetch(10'h5);
    fetch(10'h6);
    #1;
    chk("seq_ok", seq_err, 0);
    fetch(10'h8);
    #1;
    chk("seq_err", seq_err, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    ex_taken = 1'b1; ex_target = 10'h10;
    tick();
    ex_taken = 1'b0;
    tick(); tick();
    fetch(10'h10);
    #1;
    chk("seq_redirect_ok", seq_err, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
